// File: rtl/fp_div_seq_if.sv
// Operand/result bundle for the iterative floating-point divider.
// Carries the input handshake with both operands and the output handshake with result and flags.
// The master side drives operands and out_ready; the slave side (the divider) drives the rest.
interface fp_div_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         underflow;
  logic         overflow;
  logic         invalid_op;
  logic         divide_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, underflow, overflow, invalid_op, divide_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, underflow, overflow, invalid_op, divide_by_zero
  );
endinterface

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 divider a/b, radix-2 restoring, one quotient bit per clock, FTZ in and out.
// Latency: out_valid rises MAN_W+5 edges after the accept edge (28 at defaults), specials included.
// Backpressure: single-entry output held stable until out_ready; in_ready only while idle.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even, otherwise results truncate.
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_div_seq_if.slave  bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 3;          // quotient bits: integer, fraction, guard, round
  localparam int EXPX  = EXP_W + 2;          // signed working exponent width
  localparam int CNT_W = $clog2(N);

  localparam logic signed [EXPX-1:0] BIAS_S = EXPX'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EXPX-1:0] MAXE_S = EXPX'((2 ** EXP_W) - 1);
  localparam logic signed [EXPX-1:0] ONE_S  = EXPX'(1);
  localparam logic signed [EXPX-1:0] ZERO_S = '0;
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(N - 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]            a_q, a_d;
  logic [W-1:0]            b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [EXPX-1:0]  exp_q, exp_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            spec_res_q, spec_res_d;
  logic                    spec_inv_q, spec_inv_d;
  logic                    spec_dbz_q, spec_dbz_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [N-1:0]            quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            result_q, result_d;
  logic                    unf_q, unf_d;
  logic                    ovf_q, ovf_d;
  logic                    inv_q, inv_d;
  logic                    dbz_q, dbz_d;

  // Operand field decode
  logic               a_sgn, b_sgn;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sgn  = a_q[W-1];
  assign b_sgn  = b_q[W-1];
  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  // Zero exponent covers subnormals too: they are flushed to signed zero.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  // Restoring-division step: trial subtract, keep difference when non-negative
  logic [MAN_W+2:0] diff;
  logic             q_bit;

  always_comb begin
    diff  = {1'b0, rem_q} - {2'b00, mb_q};
    q_bit = ~diff[MAN_W+2];
  end

  // Normalise the quotient, round, renormalise on carry, then range-check the exponent
  logic [MAN_W:0]          norm_sig;
  logic signed [EXPX-1:0]  norm_exp;
  logic                    round_inc;
  logic [MAN_W+1:0]        rnd_sum;
  logic [MAN_W-1:0]        fin_frac;
  logic signed [EXPX-1:0]  fin_exp;
  logic [W-1:0]            rnd_res;
  logic                    rnd_ovf, rnd_unf;
`ifdef ROUND_NEAREST_EN
  logic                    grd_bit, rnd_bit;
`else
  logic                    rnd_unused;
  assign rnd_unused = quo_q[0];
`endif

  always_comb begin
    norm_sig  = quo_q[N-1] ? quo_q[N-1:2] : quo_q[N-2:1];
    norm_exp  = quo_q[N-1] ? exp_q : (exp_q - ONE_S);
`ifdef ROUND_NEAREST_EN
    grd_bit   = quo_q[N-1] ? quo_q[1] : quo_q[0];
    rnd_bit   = quo_q[N-1] ? quo_q[0] : 1'b0;
    // Round up above half, or at exactly half when the kept LSB is odd.
    round_inc = grd_bit & (rnd_bit | (rem_q != '0) | norm_sig[0]);
`else
    round_inc = 1'b0;
`endif
    rnd_sum = {1'b0, norm_sig} + {{(MAN_W+1){1'b0}}, round_inc};
    if (rnd_sum[MAN_W+1]) begin
      // Significand rounded up to 2.0: shift right and bump the exponent.
      fin_frac = rnd_sum[MAN_W:1];
      fin_exp  = norm_exp + ONE_S;
    end else begin
      fin_frac = rnd_sum[MAN_W-1:0];
      fin_exp  = norm_exp;
    end
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (fin_exp >= MAXE_S) begin
      rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_ovf = 1'b1;
    end else if (fin_exp <= ZERO_S) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
      rnd_unf = 1'b1;
    end else begin
      rnd_res = {sign_q, fin_exp[EXP_W-1:0], fin_frac};
    end
  end

  // FSM next state and datapath next values
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_inv_d = spec_inv_q;
    spec_dbz_d = spec_dbz_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    unf_d      = unf_q;
    ovf_d      = ovf_q;
    inv_d      = inv_q;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d     = a_sgn ^ b_sgn;
        exp_d      = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS_S;
        rem_d      = {1'b0, 1'b1, a_frac};
        mb_d       = {1'b1, b_frac};
        quo_d      = '0;
        cnt_d      = '0;
        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        spec_dbz_d = 1'b0;
        // Special operands still run the full count so latency never varies.
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_res_d = QNAN;
          spec_inv_d = 1'b1;
        end else if (b_zero && !a_inf) begin
          spec_res_d = {a_sgn ^ b_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          spec_dbz_d = 1'b1;
        end else if (a_inf) begin
          spec_res_d = {a_sgn ^ b_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
          spec_res_d = {a_sgn ^ b_sgn, {(W-1){1'b0}}};
        end else begin
          spec_d     = 1'b0;
          spec_res_d = '0;
        end
        state_d = S_DIVIDE;
      end

      S_DIVIDE: begin
        quo_d = {quo_q[N-2:0], q_bit};
        rem_d = q_bit ? (diff[MAN_W+1:0] << 1) : (rem_q << 1);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (spec_q) begin
          result_d = spec_res_q;
          inv_d    = spec_inv_q;
          dbz_d    = spec_dbz_q;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else begin
          result_d = rnd_res;
          inv_d    = 1'b0;
          dbz_d    = 1'b0;
          ovf_d    = rnd_ovf;
          unf_d    = rnd_unf;
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        // Flags belong to one result only; drop them as it is consumed.
        if (bus.out_ready) begin
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
          inv_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset (aborts any operation in flight)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      spec_dbz_q <= 1'b0;
      mb_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      unf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_inv_q <= spec_inv_d;
      spec_dbz_q <= spec_dbz_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
      inv_q      <= inv_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.in_ready       = (state_q == S_IDLE) && !rst;
  assign bus.out_valid      = (state_q == S_HOLD);
  assign bus.result         = result_q;
  assign bus.underflow      = unf_q;
  assign bus.overflow       = ovf_q;
  assign bus.invalid_op     = inv_q;
  assign bus.divide_by_zero = dbz_q;

endmodule
